spell_mem_gpio: RTL and testbench

Parametrised memory-mapped GPIO bank for the SPELL core's data-space I/O window. Provides `NUM_PORTS` 8-bit bidirectional ports, each with PIN/DDR/PORT registers, two-flop input synchronisers and masked pin-change detection that drives a level interrupt. It sits on the same select/addr/write bus as the other SPELL data-space peripherals and generalises the fixed two-port I/O block to N symmetric ports with interrupt capability.

---
 rtl/spell_mem_gpio_pkg.sv | 11 +
 rtl/spell_gpio_port.sv | 78 +++++++
 rtl/spell_mem_gpio.sv | 132 +++++++++++++
 tb/tb_spell_mem_gpio.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spell_mem_gpio_pkg.sv
// Shared constants for the SPELL data-space GPIO bank: per-port register
// offsets, port width and the value returned for unmapped reads.
package spell_mem_gpio_pkg;

  localparam int         PORT_W        = 8;
  localparam logic [7:0] OFS_PIN       = 8'd0;
  localparam logic [7:0] OFS_DDR       = 8'd1;
  localparam logic [7:0] OFS_PORT      = 8'd2;
  localparam logic [7:0] UNMAPPED_READ = 8'hff;

endpackage

// File: rtl/spell_gpio_port.sv
// One 8-bit GPIO port: output/enable/mask registers, a two-flop input
// synchroniser and the masked pin-change pulse.
module spell_gpio_port
  import spell_mem_gpio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] pad_in,
  input  logic [PORT_W-1:0] wdata,
  input  logic              toggle_en,
  input  logic              ddr_we,
  input  logic              port_we,
  input  logic              pcmsk_we,
  output logic [PORT_W-1:0] port_out,
  output logic [PORT_W-1:0] port_oe,
  output logic [PORT_W-1:0] pcmsk,
  output logic [PORT_W-1:0] pin_rd,
  output logic              change
);

  logic [PORT_W-1:0] out_q, out_d;
  logic [PORT_W-1:0] oe_q, oe_d;
  logic [PORT_W-1:0] msk_q, msk_d;
  logic [PORT_W-1:0] sync1_q, sync1_d;
  logic [PORT_W-1:0] sync2_q, sync2_d;
  logic [PORT_W-1:0] prev_q, prev_d;

  // Next-state for the register file and the synchroniser chain.
  always_comb begin
    if (toggle_en) begin
      out_d = out_q ^ wdata;
    end else if (port_we) begin
      out_d = wdata;
    end else begin
      out_d = out_q;
    end
    if (ddr_we) begin
      oe_d = wdata;
    end else begin
      oe_d = oe_q;
    end
    if (pcmsk_we) begin
      msk_d = wdata;
    end else begin
      msk_d = msk_q;
    end
    sync1_d = pad_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= {PORT_W{1'b0}};
      oe_q    <= {PORT_W{1'b0}};
      msk_q   <= {PORT_W{1'b0}};
      sync1_q <= {PORT_W{1'b0}};
      sync2_q <= {PORT_W{1'b0}};
      prev_q  <= {PORT_W{1'b0}};
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      msk_q   <= msk_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign port_out = out_q;
  assign port_oe  = oe_q;
  assign pcmsk    = msk_q;
  // A PIN read captures the value sync2 takes at the same edge.
  assign pin_rd   = sync2_d;
  assign change   = |((sync2_q ^ prev_q) & msk_q);

endmodule

// File: rtl/spell_mem_gpio.sv
// Memory-mapped GPIO bank: address decode, registered read mux, pin-change
// flag register (write-1-to-clear, set wins) and level interrupt.
module spell_mem_gpio
  import spell_mem_gpio_pkg::*;
#(
  parameter int         NUM_PORTS = 2,
  parameter logic [7:0] BASE_ADDR = 8'h30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          select,
  input  logic [7:0]                    addr,
  input  logic [7:0]                    data_in,
  input  logic                          write,
  output logic [7:0]                    data_out,
  output logic                          data_ready,
  input  logic [PORT_W*NUM_PORTS-1:0]   port_in,
  output logic [PORT_W*NUM_PORTS-1:0]   port_out,
  output logic [PORT_W*NUM_PORTS-1:0]   port_oe,
  output logic                          irq
);

  logic [7:0]                        offs;
  logic                              wr_sel;
  logic [NUM_PORTS-1:0]              toggle_en, ddr_we, port_we, pcmsk_we;
  logic [NUM_PORTS-1:0]              change_vec;
  logic [NUM_PORTS-1:0]              pcifr_clr;
  logic [NUM_PORTS-1:0][PORT_W-1:0]  pin_rd, pcmsk_rd, out_rd, oe_rd;
  logic [7:0]                        pcifr_ext;
  logic [7:0]                        rd_data;

  logic [NUM_PORTS-1:0] pcifr_q, pcifr_d;
  logic                 past_write_q, past_write_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 data_ready_q, data_ready_d;

  assign offs   = addr - BASE_ADDR;
  assign wr_sel = select & write;

  // Address decode, write strobes and read mux.
  always_comb begin
    toggle_en = {NUM_PORTS{1'b0}};
    ddr_we    = {NUM_PORTS{1'b0}};
    port_we   = {NUM_PORTS{1'b0}};
    pcmsk_we  = {NUM_PORTS{1'b0}};
    pcifr_clr = {NUM_PORTS{1'b0}};
    pcifr_ext = 8'h00;
    pcifr_ext[NUM_PORTS-1:0] = pcifr_q;
    rd_data   = UNMAPPED_READ;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (offs == 8'(3 * p) + OFS_PIN) begin
        rd_data      = pin_rd[p];
        toggle_en[p] = wr_sel & ~past_write_q;
      end else if (offs == 8'(3 * p) + OFS_DDR) begin
        rd_data   = oe_rd[p];
        ddr_we[p] = wr_sel;
      end else if (offs == 8'(3 * p) + OFS_PORT) begin
        rd_data    = out_rd[p];
        port_we[p] = wr_sel;
      end else if (offs == 8'(3 * NUM_PORTS + p)) begin
        rd_data     = pcmsk_rd[p];
        pcmsk_we[p] = wr_sel;
      end else begin
        rd_data = rd_data;
      end
    end
    if (offs == 8'(4 * NUM_PORTS)) begin
      rd_data = pcifr_ext;
      if (wr_sel) begin
        pcifr_clr = data_in[NUM_PORTS-1:0];
      end else begin
        pcifr_clr = {NUM_PORTS{1'b0}};
      end
    end else begin
      pcifr_clr = pcifr_clr;
    end
  end

  // Bus response and flag next-state; a new change outranks a same-cycle clear.
  always_comb begin
    past_write_d = wr_sel;
    data_ready_d = select;
    if (wr_sel) begin
      data_out_d = 8'h00;
    end else if (select) begin
      data_out_d = rd_data;
    end else begin
      data_out_d = data_out_q;
    end
    pcifr_d = (pcifr_q & ~pcifr_clr) | change_vec;
  end

  // Top-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcifr_q      <= {NUM_PORTS{1'b0}};
      past_write_q <= 1'b0;
      data_out_q   <= 8'h00;
      data_ready_q <= 1'b0;
    end else begin
      pcifr_q      <= pcifr_d;
      past_write_q <= past_write_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    spell_gpio_port u_port (
      .clk       (clk),
      .rst       (rst),
      .pad_in    (port_in[PORT_W*p +: PORT_W]),
      .wdata     (data_in),
      .toggle_en (toggle_en[p]),
      .ddr_we    (ddr_we[p]),
      .port_we   (port_we[p]),
      .pcmsk_we  (pcmsk_we[p]),
      .port_out  (out_rd[p]),
      .port_oe   (oe_rd[p]),
      .pcmsk     (pcmsk_rd[p]),
      .pin_rd    (pin_rd[p]),
      .change    (change_vec[p])
    );
    assign port_out[PORT_W*p +: PORT_W] = out_rd[p];
    assign port_oe[PORT_W*p +: PORT_W]  = oe_rd[p];
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign irq        = |pcifr_q;

endmodule

// File: tb/tb_spell_mem_gpio.sv
// Directed bench for spell_mem_gpio (NUM_PORTS=2, BASE_ADDR=8'h30) with a
// read-data scoreboard queue.
module tb_spell_mem_gpio;

  logic        clk;
  logic        rst;
  logic        select;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic        write;
  logic [7:0]  data_out;
  logic        data_ready;
  logic [15:0] port_in;
  logic [15:0] port_out;
  logic [15:0] port_oe;
  logic        irq;

  int checks;
  int failures;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  spell_mem_gpio #(.NUM_PORTS(2), .BASE_ADDR(8'h30)) dut (
    .clk        (clk),
    .rst        (rst),
    .select     (select),
    .addr       (addr),
    .data_in    (data_in),
    .write      (write),
    .data_out   (data_out),
    .data_ready (data_ready),
    .port_in    (port_in),
    .port_out   (port_out),
    .port_oe    (port_oe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    string      t;
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, {24'd0, data_out}, {24'd0, e});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    select = 1'b0;
    write  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    select = 1'b1;
    write  = 1'b0;
    addr   = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check({tag, "_rdy"}, {31'd0, data_ready}, 32'd1);
    pop_check();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int cycles);
    @(negedge clk);
    select  = 1'b1;
    write   = 1'b1;
    addr    = a;
    data_in = d;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("wr_dout_zero", {24'd0, data_out}, 32'd0);
    end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    select   = 1'b0;
    write    = 1'b0;
    addr     = 8'h00;
    data_in  = 8'h00;
    port_in  = 16'h0000;

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    check("rst_port_out", {16'd0, port_out}, 32'd0);
    check("rst_port_oe", {16'd0, port_oe}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdy", {31'd0, data_ready}, 32'd0);
    check("rst_dout", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h30, 8'h00, "rst_pin0");
    do_read(8'h31, 8'h00, "rst_ddr0");
    do_read(8'h32, 8'h00, "rst_port0");
    idle();
    check("rdy_drop", {31'd0, data_ready}, 32'd0);

    // DDR / PORT on port 1
    do_write(8'h34, 8'hf0, 1);
    do_write(8'h35, 8'ha5, 1);
    check("ddr1_oe", {24'd0, port_oe[15:8]}, 32'hf0);
    check("port1_out", {24'd0, port_out[15:8]}, 32'ha5);
    do_read(8'h34, 8'hf0, "ddr1_rb");
    do_read(8'h35, 8'ha5, "port1_rb");

    // PIN toggle: held strobe toggles once
    do_write(8'h32, 8'h0f, 1);
    check("port0_0f", {24'd0, port_out[7:0]}, 32'h0f);
    do_write(8'h30, 8'hff, 3);
    check("toggle_3cyc", {24'd0, port_out[7:0]}, 32'hf0);
    do_write(8'h30, 8'hff, 2);
    check("toggle_2cyc", {24'd0, port_out[7:0]}, 32'h0f);

    // Input synchroniser latency: read at E1 sees old, read at E2 sees new
    @(negedge clk);
    port_in[7:0] = 8'h81;
    select = 1'b1;
    write  = 1'b0;
    addr   = 8'h30;
    exp_q.push_back(8'h00); tag_q.push_back("pin_e1");
    exp_q.push_back(8'h81); tag_q.push_back("pin_e2");
    @(posedge clk); #1; pop_check();
    @(posedge clk); #1; pop_check();
    idle();

    // Pin-change interrupt
    do_write(8'h36, 8'h01, 1);
    do_read(8'h36, 8'h01, "pcmsk0_rb");
    @(negedge clk);
    port_in[7:0] = 8'h83;
    repeat (5) @(posedge clk);
    #1;
    check("irq_masked", {31'd0, irq}, 32'd0);
    do_read(8'h38, 8'h00, "pcifr_masked");
    idle();
    @(negedge clk);
    port_in[7:0] = 8'h82;
    @(posedge clk); #1; check("irq_e1", {31'd0, irq}, 32'd0);
    @(posedge clk); #1; check("irq_e2", {31'd0, irq}, 32'd0);
    @(posedge clk); #1; check("irq_e3", {31'd0, irq}, 32'd1);
    do_read(8'h38, 8'h01, "pcifr_set");
    do_write(8'h38, 8'h01, 1);
    check("irq_w1c", {31'd0, irq}, 32'd0);

    // Set and clear in the same cycle: set wins
    @(negedge clk);
    port_in[7:0] = 8'h83;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    select  = 1'b1;
    write   = 1'b1;
    addr    = 8'h38;
    data_in = 8'h01;
    @(posedge clk);
    #1;
    check("collide_irq", {31'd0, irq}, 32'd1);
    idle();
    do_read(8'h38, 8'h01, "collide_pcifr");
    do_write(8'h38, 8'h01, 1);
    check("collide_clear", {31'd0, irq}, 32'd0);

    // Unmapped access
    do_read(8'h39, 8'hff, "unmap_rd39");
    do_read(8'h2f, 8'hff, "unmap_rd2f");
    do_write(8'h39, 8'hff, 1);
    check("unmap_out", {16'd0, port_out}, 32'ha50f);
    check("unmap_oe", {16'd0, port_oe}, 32'hf000);
    check("unmap_irq", {31'd0, irq}, 32'd0);
    do_read(8'h36, 8'h01, "unmap_pcmsk");

    // Reset during a write: the access is lost
    @(negedge clk);
    select  = 1'b1;
    write   = 1'b1;
    addr    = 8'h35;
    data_in = 8'h11;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_out", {16'd0, port_out}, 32'd0);
    check("rstmid_rdy", {31'd0, data_ready}, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    select = 1'b0;
    write  = 1'b0;
    do_write(8'h30, 8'h3c, 2);
    check("post_rst_toggle", {24'd0, port_out[7:0]}, 32'h3c);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
